// File: rtl/mem_req_ctrl.sv
// Initiator-side data-memory controller: sequences single word/byte loads and
// stores onto a word-wide, big-endian, registered-read RAM port.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_d,
  output logic [31:0] ram_ad,
  output logic        ram_we,
  output logic        ram_en,
  input  logic [31:0] ram_q
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  // Highest legal start address: every access touches four bytes.
  localparam logic [31:0] LAST_WORD = 32'((64'd1 << ADDR_WIDTH) - 64'd4);

  state_t      state;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;
  logic        byte_r;
  logic [23:0] rmw_buf;
  logic        range_err;
  logic        ram_active;

  assign range_err  = (req_addr > LAST_WORD);
  assign ram_active = (state == READ) || (state == WAIT) || (state == WRITE);
  assign req_ready  = (state == IDLE);

  // RAM port is decoded from state and captured registers only, so a reset
  // that lands in WRITE removes the write enable before the next edge.
  assign ram_en = ram_active;
  assign ram_we = (state == WRITE);
  assign ram_ad = ram_active ? addr_r : '0;
  assign ram_d  = (state != WRITE) ? '0 :
                  (byte_r ? {wdata_r[7:0], rmw_buf} : wdata_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_r    <= '0;
      wdata_r   <= '0;
      we_r      <= 1'b0;
      byte_r    <= 1'b0;
      rmw_buf   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            we_r    <= req_we;
            byte_r  <= req_byte;
            if (range_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && !req_byte) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          // Only byte stores reach WAIT with we set; they merge the old word.
          if (we_r) begin
            rmw_buf <= ram_q[23:0];
            state   <= WRITE;
          end else begin
            rsp_rdata <= byte_r ? {24'b0, ram_q[31:24]} : ram_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator side of the data-memory interface. Accepts single load/store requests from the CPU datapath and sequences them onto the byte-addressed, big-endian, word-wide RAM port (d, ad, we, en, q).
- Adds byte loads (ldrb) and byte stores (strb, via read-modify-write) on top of the word-only RAM.
- Returns one response per request and flags out-of-range addresses without touching memory.

Parameters:
- ADDR_WIDTH, 8, RAM size in bytes as a log2 value; it must match the attached RAM's ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  `FULLW  byte address; unaligned addresses are legal.
- req_wdata  in  `FULLW  store data; a byte store uses bits [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  `FULLW  load result; 0 for stores and errors.
- rsp_err  out  1  out-of-range access; qualified by rsp_valid.
- ram_d  out  `FULLW  RAM write data.
- ram_ad  out  `FULLW  RAM byte address.
- ram_we  out  1  RAM write enable.
- ram_en  out  1  RAM chip enable.
- ram_q  in  `FULLW  RAM registered read data; valid the cycle after an enabled edge.

Behaviour:
- RAM model:
  - A word at ad is big-endian: mem[ad] sits in bits [31:24].
  - q updates one edge after en=1.
  - en=0 clears q on the next edge.
  - Read data returns pre-write contents.
- States: IDLE, READ, WAIT, WRITE, RESP.
- Handshake:
  - A request is accepted at the edge where req_valid && req_ready.
  - The edge captures addr, wdata, we and byte into internal registers.
  - Request inputs are ignored outside IDLE.
- Range check at acceptance: range_err = (req_addr > 2^ADDR_WIDTH - 4), a 32-bit unsigned compare.
  - The check applies to byte ops too, because the RAM always touches 4 bytes.
  - If set: IDLE -> RESP with rsp_err=1 and rsp_rdata=0. No ram_en is asserted.
- Word store: IDLE -> WRITE -> RESP -> IDLE.
- Word load and byte load: IDLE -> READ -> WAIT -> RESP -> IDLE.
- Byte store: IDLE -> READ -> WAIT -> WRITE -> RESP -> IDLE.
- READ: ram_en=1, ram_we=0, ram_ad=addr.
- WAIT:
  - ram_en=1, ram_we=0, ram_ad=addr.
  - ram_q is registered at the end of WAIT.
  - Word load captures ram_q into rsp_rdata.
  - Byte load captures {24'b0, ram_q[31:24]} into rsp_rdata.
  - Byte store captures ram_q into an internal buffer.
- WRITE:
  - ram_en=1, ram_we=1, ram_ad=addr.
  - Word store drives ram_d=wdata.
  - Byte store drives ram_d={wdata[7:0], buf[23:0]}. Only mem[addr] changes value.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata holds the loaded value; it is 0 for stores.
  - There is no response backpressure.
- Outside READ/WAIT/WRITE: ram_en=0, ram_we=0, ram_ad=0, ram_d=0.
- Outputs are registered or decoded from state only; there is no combinational path from req_* to ram_*.
- Latency from the accept edge to the rsp_valid cycle:
  - word store: 2 cycles
  - loads: 3 cycles
  - byte store: 4 cycles
  - error: 1 cycle
- Throughput: the next request can be accepted at the edge ending the cycle after RESP (IDLE). At most one request is in flight.
- Reset (rst_n=0, any time):
  - State goes to IDLE immediately.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, buffer=0.
  - ram_en=0, ram_we=0, ram_ad=0, ram_d=0; req_ready=1 once the FSM is in IDLE.
  - An in-flight request is dropped with no response.
  - A WRITE cut by reset before its edge does not write.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> first store rsp_valid 2 cycles after accept, exactly one write with ram_ad=0x10; load rsp_rdata=0xDEADBEEF 3 cycles after its accept, rsp_err=0.
- Byte load @0x11 after the above -> rsp_rdata=0x000000AD. Byte load @0x13 -> 0x000000EF.
- RAM bytes 0x14/0x15 preloaded with 0; byte store wdata=0x12345655 @0x12 -> one write with ram_ad=0x12, ram_d=0x55EF0000; subsequent word load @0x10 returns 0xDEAD55EF.
- Word load @0xFC -> normal response. Word load @0xFD and byte store @0xFF -> rsp_err=1, rsp_rdata=0, ram_en never asserted, rsp_valid 1 cycle after accept.
- req_valid held high with two queued loads -> req_ready=0 from the accept edge through RESP. Second request accepted only in IDLE. Exactly two rsp_valid pulses, in order.
- Assert rst_n=0 during WAIT of a byte store -> ram_we never asserted, no rsp_valid, all outputs 0 and req_ready=1 after reset; RAM contents unchanged.
